// File: rtl/apr_pkg.sv
// Shared types and constants for the APR fast-memory parity checker.
package apr_pkg;

  // Captured AC location: block in the upper bits, address in the lower.
  typedef struct packed {
    logic [2:0] blk;
    logic [3:0] adr;
  } fm_addr_t;

  // Bit positions inside the 16-bit diag readout word.
  localparam int unsigned DIAG_ERR     = 15;
  localparam int unsigned DIAG_OVF     = 14;
  localparam int unsigned DIAG_CNT_LSB = 10;
  localparam int unsigned DIAG_BLK_LSB = 7;
  localparam int unsigned DIAG_ADR_LSB = 3;

  // Saturation value of the error counter.
  localparam int unsigned CNT_MAX = 15;

endpackage : apr_pkg

// File: rtl/fm_parity_tree.sv
// XOR reduction across the EDP slice parities (36 data bits total).
module fm_parity_tree #(
  parameter int unsigned N_SLICES = 6
) (
  input  logic [N_SLICES-1:0] slice_par_i,
  output logic                parity_o
);

  assign parity_o = ^slice_par_i;

endmodule : fm_parity_tree

// File: rtl/apr_fm_parity_check.sv
// Fast-memory parity generator/checker with error latch, counter,
// interrupt request and diag readout.
module apr_fm_parity_check
  import apr_pkg::*;
#(
  parameter int unsigned N_SLICES = 6,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk_apr_h,
  input  logic                apr_reset_l,
  input  logic [N_SLICES-1:0] edp_fm_parity_h,
  input  logic                fm_parity_rd_h,
  input  logic                con_fm_read_h,
  input  logic                con_fm_write_l,
  input  logic [2:0]          apr_fm_block_h,
  input  logic [3:0]          apr_fm_adr_h,
  input  logic                apr_fm_par_en_h,
  input  logic                apr_clr_err_h,
  input  logic                apr_intr_ack_h,
  input  logic                diag_read_func_13x_h,
  output logic                fm_parity_wr_h,
  output logic                apr_fm_par_err_h,
  output logic                apr_fm_par_intr_h,
  output logic [15:0]         diag_data_h
);

  localparam logic [CNT_W-1:0] CntSat = CNT_W'(CNT_MAX);

  logic             rst_meta_q, rst_sync_q;
  logic             tree_par;
  logic             bad;
  logic             pv_q, pv_d;
  fm_addr_t         padr_q, padr_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fm_addr_t         addr_q, addr_d;
  logic             intr_q, intr_d;
  logic [15:0]      diag_q, diag_d;

  // Reset synchronizer: asynchronous assert, release aligned to the clock.
  always_ff @(posedge clk_apr_h or negedge apr_reset_l) begin
    if (!apr_reset_l) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // One parity tree serves both write generation and read checking.
  fm_parity_tree #(.N_SLICES(N_SLICES)) u_tree (
    .slice_par_i (edp_fm_parity_h),
    .parity_o    (tree_par)
  );

  assign fm_parity_wr_h = ~tree_par;

  // Read in flight one clock ago; total parity with the stored bit must be odd.
  // The bad strobe is registered directly into the error latch, so the event
  // becomes visible two clocks after the read.
  assign bad = pv_q & apr_fm_par_en_h & ~(tree_par ^ fm_parity_rd_h);

  // Read pipe stage: flag a read cycle and hold its location.
  always_comb begin
    pv_d   = con_fm_read_h & con_fm_write_l;
    padr_d = padr_q;
    if (pv_d) begin
      padr_d.blk = apr_fm_block_h;
      padr_d.adr = apr_fm_adr_h;
    end
  end

  // Error latch, counter and interrupt; an event overrides a coincident clear/ack.
  always_comb begin
    err_d  = err_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    intr_d = intr_q;
    if (bad) begin
      err_d  = 1'b1;
      intr_d = 1'b1;
      if (apr_clr_err_h) begin
        cnt_d  = CNT_W'(1);
        ovf_d  = 1'b0;
        addr_d = padr_q;
      end else begin
        if (!err_q) begin
          addr_d = padr_q;
        end
        if (cnt_q == CntSat) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (apr_clr_err_h) begin
      err_d  = 1'b0;
      ovf_d  = 1'b0;
      cnt_d  = '0;
      addr_d = '0;
      intr_d = 1'b0;
    end else if (apr_intr_ack_h) begin
      intr_d = 1'b0;
    end
  end

  // Diag word assembly; zero when not selected.
  always_comb begin
    diag_d = '0;
    if (diag_read_func_13x_h) begin
      diag_d[DIAG_ERR]                   = err_q;
      diag_d[DIAG_OVF]                   = ovf_q;
      diag_d[DIAG_CNT_LSB +: CNT_W]      = cnt_q;
      diag_d[DIAG_BLK_LSB +: 3]          = addr_q.blk;
      diag_d[DIAG_ADR_LSB +: 4]          = addr_q.adr;
    end
  end

  // State registers.
  always_ff @(posedge clk_apr_h or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      pv_q   <= 1'b0;
      padr_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      intr_q <= 1'b0;
      diag_q <= '0;
    end else begin
      pv_q   <= pv_d;
      padr_q <= padr_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      intr_q <= intr_d;
      diag_q <= diag_d;
    end
  end

  assign apr_fm_par_err_h  = err_q;
  assign apr_fm_par_intr_h = intr_q;
  assign diag_data_h       = diag_q;

endmodule : apr_fm_parity_check

// File: tb/tb_apr_fm_parity_check.sv
// Self-checking bench for apr_fm_parity_check.
module tb_apr_fm_parity_check;

  logic        clk;
  logic        rst_l;
  logic [5:0]  slices;
  logic        stored;
  logic        rd;
  logic        wr_l;
  logic [2:0]  blk;
  logic [3:0]  adr;
  logic        en;
  logic        clr;
  logic        ack;
  logic        dsel;
  logic        par_wr;
  logic        err;
  logic        intr;
  logic [15:0] diag;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [2:0] blk;
    logic [3:0] adr;
    logic [5:0] slices;
    logic       stored;
    logic       en;
    logic       exp_err;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] sb_q [$];
  logic [15:0] d;
  logic [15:0] exp_d;

  apr_fm_parity_check #(.N_SLICES(6), .CNT_W(4)) dut (
    .clk_apr_h            (clk),
    .apr_reset_l          (rst_l),
    .edp_fm_parity_h      (slices),
    .fm_parity_rd_h       (stored),
    .con_fm_read_h        (rd),
    .con_fm_write_l       (wr_l),
    .apr_fm_block_h       (blk),
    .apr_fm_adr_h         (adr),
    .apr_fm_par_en_h      (en),
    .apr_clr_err_h        (clr),
    .apr_intr_ack_h       (ack),
    .diag_read_func_13x_h (dsel),
    .fm_parity_wr_h       (par_wr),
    .apr_fm_par_err_h     (err),
    .apr_fm_par_intr_h    (intr),
    .diag_data_h          (diag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Single read: location in cycle T, slice/stored data in T+1; returns at T+2.
  task automatic do_read(input logic [2:0] b, input logic [3:0] a,
                         input logic [5:0] s, input logic st, input logic e);
    rd  = 1'b1;
    blk = b;
    adr = a;
    tick();
    rd     = 1'b0;
    slices = s;
    stored = st;
    en     = e;
    tick();
    en = 1'b1;
  endtask

  task automatic read_diag(output logic [15:0] v);
    dsel = 1'b1;
    tick();
    v    = diag;
    dsel = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd3, 4'd5,  6'b000001, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'd2, 4'd9,  6'b000011, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{3'd4, 4'd0,  6'b000011, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd5, 4'd12, 6'b111111, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{3'd6, 4'd3,  6'b101010, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'd0, 4'd15, 6'b000000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{3'd7, 4'd1,  6'b000000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{3'd1, 4'd6,  6'b000011, 1'b0, 1'b0, 1'b0};

    // Test 1: reset with a bad read held active.
    rst_l = 1'b0; rd = 1'b1; wr_l = 1'b1; blk = 3'd2; adr = 4'd9;
    slices = 6'b000011; stored = 1'b0; en = 1'b1; clr = 1'b0; ack = 1'b0; dsel = 1'b1;
    repeat (3) tick();
    chk("rst_err",  {15'd0, err},  16'd0);
    chk("rst_intr", {15'd0, intr}, 16'd0);
    chk("rst_diag", diag, 16'h0000);
    rd = 1'b0; dsel = 1'b0;
    rst_l = 1'b1;
    repeat (5) tick();
    chk("post_rst_err",  {15'd0, err},  16'd0);
    chk("post_rst_intr", {15'd0, intr}, 16'd0);

    // Reset landing mid-check drops the in-flight read.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    #1 rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    repeat (5) tick();
    chk("midchk_rst_err", {15'd0, err}, 16'd0);

    // Table: isolated reads from a cleared state, scoreboard of diag words.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      sb_q.push_back(vecs[i].exp_err ?
                     {1'b1, 1'b0, 4'd1, vecs[i].blk, vecs[i].adr, 3'b000} : 16'h0000);
      do_read(vecs[i].blk, vecs[i].adr, vecs[i].slices, vecs[i].stored, vecs[i].en);
      chk($sformatf("vec%0d_err", i),  {15'd0, err},  {15'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_intr", i), {15'd0, intr}, {15'd0, vecs[i].exp_err});
      read_diag(d);
      exp_d = sb_q.pop_front();
      chk($sformatf("vec%0d_diag", i), d, exp_d);
    end
    tick();
    chk("diag_unselected", diag, 16'h0000);

    // Test 3: diag word and ack behaviour.
    do_clear();
    do_read(3'd2, 4'd9, 6'b000011, 1'b0, 1'b1);
    read_diag(d);
    chk("t3_diag", d, 16'h8548);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t3_ack_intr", {15'd0, intr}, 16'd0);
    chk("t3_ack_err",  {15'd0, err},  16'd1);
    // Ack coincident with an event leaves intr set.
    rd = 1'b1;
    tick();
    rd = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_vs_event_intr", {15'd0, intr}, 16'd1);

    // Test 4: 16 back-to-back bad reads, first at blk=1 adr=4.
    do_clear();
    slices = 6'b000011; stored = 1'b0;
    rd = 1'b1; blk = 3'd1; adr = 4'd4;
    tick();
    blk = 3'd3; adr = 4'd2;
    repeat (15) tick();
    rd = 1'b0;
    tick();
    read_diag(d);
    chk("t4_sat_diag", d, 16'hFCA0);

    // Test 5: clear coincident with a bad read at blk=7 adr=15.
    rd = 1'b1; blk = 3'd7; adr = 4'd15;
    tick();
    rd = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_intr", {15'd0, intr}, 16'd1);
    read_diag(d);
    chk("t5_diag", d, 16'h87F8);

    // Test 6: write path generates parity and never starts a check.
    do_clear();
    wr_l = 1'b0; rd = 1'b1; slices = 6'b000111; stored = 1'b0;
    #1 chk("wr_par_odd3", {15'd0, par_wr}, 16'd0);
    slices = 6'b000011;
    #1 chk("wr_par_even", {15'd0, par_wr}, 16'd1);
    tick();
    wr_l = 1'b1; rd = 1'b0;
    repeat (2) tick();
    chk("wr_no_check", {15'd0, err}, 16'd0);
    // Bad read with checking disabled at T+1.
    do_read(3'd5, 4'd5, 6'b000011, 1'b0, 1'b0);
    tick();
    chk("dis_err", {15'd0, err}, 16'd0);
    read_diag(d);
    chk("dis_diag", d, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_apr_fm_parity_check
